// File: rtl/topk_score_buffer.sv
// Streaming top-K buffer: keeps the DEPTH best-scoring candidates of a pass sorted
// descending, then drains them best first. Optional `TOPK_MIN_SCORE_EN adds a min_score filter.
module topk_score_buffer #(
    parameter int unsigned DEPTH   = 10,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned TAG_W   = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
`ifdef TOPK_MIN_SCORE_EN
    input  logic [SCORE_W-1:0]           min_score,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SCORE_W-1:0]           in_score,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SCORE_W-1:0]           out_score,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(DEPTH)-1:0]     out_rank,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done
);

    localparam int unsigned RANK_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q [DEPTH];
    logic [SCORE_W-1:0] score_d [DEPTH];
    logic [TAG_W-1:0]   tag_q   [DEPTH];
    logic [TAG_W-1:0]   tag_d   [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [RANK_W-1:0]  rank_q, rank_d;
    logic               done_q, done_d;

    logic               accept;
    logic               eligible;
    logic [CNT_W-1:0]   ins_pos;
    logic               ins_ok;
    logic               drain_hs;
    logic               drain_last;

    assign in_ready  = (state_q != ST_DRAIN);
    assign accept    = in_valid & in_ready & ~clear;
    assign out_valid = (state_q == ST_DRAIN) && (count_q != '0);
    assign out_score = out_valid ? score_q[rank_q] : '0;
    assign out_tag   = out_valid ? tag_q[rank_q] : '0;
    assign out_rank  = rank_q;
    assign count     = count_q;
    assign done      = done_q;

    assign drain_hs   = out_valid & out_ready;
    assign drain_last = (CNT_W'(rank_q) == count_q - CNT_W'(1));

`ifdef TOPK_MIN_SCORE_EN
    assign eligible = (in_score >= min_score);
`else
    assign eligible = 1'b1;
`endif

    // Insertion slot lands after every stored entry whose score is >= the newcomer,
    // so ties keep arrival order and a full buffer rejects scores <= the worst entry.
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (score_q[i] >= in_score)) begin
                ins_pos = ins_pos + CNT_W'(1);
            end
        end
    end

    assign ins_ok = accept & eligible & (ins_pos < CNT_W'(DEPTH));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rank_d  = rank_q;
        done_d  = 1'b0;
        score_d = score_q;
        tag_d   = tag_q;

        if (ins_ok) begin
            if (ins_pos == '0) begin
                score_d[0] = in_score;
                tag_d[0]   = in_tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (ins_pos == CNT_W'(i)) begin
                    score_d[i] = in_score;
                    tag_d[i]   = in_tag;
                end else if (ins_pos < CNT_W'(i)) begin
                    score_d[i] = score_q[i-1];
                    tag_d[i]   = tag_q[i-1];
                end
            end
            if (count_q < CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_FILL: begin
                rank_d = '0;
                if (accept) begin
                    state_d = in_last ? ST_DRAIN : ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (drain_hs) begin
                    if (drain_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        count_d = '0;
                        rank_d  = '0;
                        for (int i = 0; i < DEPTH; i++) begin
                            score_d[i] = '0;
                            tag_d[i]   = '0;
                        end
                    end else begin
                        rank_d = rank_q + RANK_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Restart wins over everything except reset; any offered candidate is dropped.
        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            rank_d  = '0;
            done_d  = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                score_d[i] = '0;
                tag_d[i]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rank_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                score_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rank_q  <= rank_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                score_q[i] <= score_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_topk_score_buffer.sv
// Scoreboard bench for topk_score_buffer: a stable-sort top-K model predicts each drain,
// a negedge monitor checks outputs and done timing. Define TOPK_MIN_SCORE_EN to test the filter.
module tb_topk_score_buffer;

    localparam int DEPTH = 10;
    localparam int SW    = 8;
    localparam int TW    = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] in_score = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [SW-1:0] out_score;
    logic [TW-1:0] out_tag;
    logic [3:0]    out_rank;
    logic [3:0]    count;
    logic          done;
`ifdef TOPK_MIN_SCORE_EN
    logic [SW-1:0] min_score = '0;
`endif

    topk_score_buffer #(.DEPTH(DEPTH), .SCORE_W(SW), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
`ifdef TOPK_MIN_SCORE_EN
        .min_score (min_score),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .in_tag    (in_tag),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_tag   (out_tag),
        .out_rank  (out_rank),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] s;
        logic [TW-1:0] t;
        int            r;
    } item_t;

    typedef struct {
        int sz;
        int acc_cyc;
    } pass_t;

    item_t pass_c[$];
    item_t exp_q[$];
    pass_t pass_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_hs = -10;
    int rdy_mode = 0;
    int pidx = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: compare presented entries against the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    check("out_score", 64'(out_score), 64'(exp_q[0].s));
                    check("out_tag", 64'(out_tag), 64'(exp_q[0].t));
                    check("out_rank", 64'(out_rank), 64'(exp_q[0].r));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        last_hs = cyc;
                    end
                end
            end
            if (done) begin
                if (pass_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    pass_t p;
                    p = pass_q.pop_front();
                    check("done_left_entries", 64'(exp_q.size()), 64'd0);
                    if (p.sz > 0) check("done_timing", 64'(cyc), 64'(last_hs + 1));
                    else          check("done_timing_empty", 64'(cyc), 64'(p.acc_cyc + 1));
                end
            end
        end
    end

    task automatic model_accept(input logic [SW-1:0] s, input logic [TW-1:0] t);
        item_t c;
        bit    keep;
        keep = 1'b1;
`ifdef TOPK_MIN_SCORE_EN
        keep = (s >= min_score);
`endif
        c.s = s;
        c.t = t;
        c.r = 0;
        if (keep) pass_c.push_back(c);
    endtask

    // Stable sort of the whole pass by descending score, then keep the first DEPTH.
    task automatic model_last();
        item_t srt[$];
        pass_t p;
        int    n;
        foreach (pass_c[k]) begin
            int pos;
            pos = 0;
            while (pos < srt.size() && srt[pos].s >= pass_c[k].s) pos++;
            srt.insert(pos, pass_c[k]);
        end
        n = (srt.size() < DEPTH) ? srt.size() : DEPTH;
        for (int r = 0; r < n; r++) begin
            item_t e;
            e = srt[r];
            e.r = r;
            exp_q.push_back(e);
        end
        p.sz = n;
        p.acc_cyc = cyc;
        pass_q.push_back(p);
        pass_c.delete();
    endtask

    task automatic send(input logic [SW-1:0] s, input logic [TW-1:0] t, input logic last);
        bit acc;
        int guard;
        int exp_cnt;
        acc = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        in_score = s;
        in_tag = t;
        in_last = last;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            model_accept(s, t);
            exp_cnt = (pass_c.size() < DEPTH) ? pass_c.size() : DEPTH;
            check("count", 64'(count), 64'(exp_cnt));
            if (last) model_last();
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((pass_q.size() != 0 || exp_q.size() != 0) && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        if (guard >= 2000) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_out_score"}, 64'(out_score), 64'd0);
        check({tag, "_out_tag"}, 64'(out_tag), 64'd0);
        check({tag, "_out_rank"}, 64'(out_rank), 64'd0);
    endtask

    initial begin
        int sc [5];
        sc = '{5, 9, 1, 9, 7};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic ordering with a tie: earlier 9 must rank first.
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send(SW'(sc[i]), TW'(i + 1), i == 4);
        wait_idle();

        // Ascending 1..15: only 15 down to 6 survive.
        for (int i = 1; i <= 15; i++) send(SW'(i), TW'(100 + i), i == 15);
        wait_idle();

        // Full buffer with worst = 20: another 20 and a low last score are discarded.
        for (int i = 0; i < 10; i++) send(SW'(29 - i), TW'(200 + i), 1'b0);
        send(SW'(20), TW'(299), 1'b0);
        send(SW'(3), TW'(298), 1'b1);
        wait_idle();

        // Stalled drain with out_ready pattern 1,0,0,1.
        rdy_mode = 2;
        pidx = 0;
        for (int i = 0; i < 7; i++) send(SW'($urandom_range(0, 255)), TW'($urandom), i == 6);
        wait_idle();
        rdy_mode = 0;

        // Clear mid-FILL with a simultaneous candidate offered.
        for (int i = 0; i < 6; i++) send(SW'($urandom_range(0, 255)), TW'($urandom), 1'b0);
        in_valid = 1'b1;
        in_score = 8'd200;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        pass_c.delete();
        check("clear_count", 64'(count), 64'd0);
        check("clear_in_ready", 64'(in_ready), 64'd1);
        check("clear_done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a stalled drain.
        rdy_mode = 3;
        for (int i = 0; i < 4; i++) send(SW'($urandom_range(0, 255)), TW'($urandom), i == 3);
        for (int g = 0; g < 20 && !out_valid; g++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("mid_drain_rst");
        exp_q.delete();
        pass_q.delete();
        pass_c.delete();
        rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Randomized passes, narrow score range on odd passes to force ties.
        for (int p = 0; p < 8; p++) begin
            int len;
            len = $urandom_range(1, 20);
            rdy_mode = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                send((p % 2) ? SW'($urandom_range(0, 7)) : SW'($urandom_range(0, 255)),
                     TW'($urandom), i == len - 1);
            end
            wait_idle();
        end
        rdy_mode = 0;

`ifdef TOPK_MIN_SCORE_EN
        min_score = 8'd50;
        send(8'd40, 24'd1, 1'b0);
        send(8'd60, 24'd2, 1'b0);
        send(8'd50, 24'd3, 1'b1);
        wait_idle();
        send(8'd40, 24'd4, 1'b1);
        wait_idle();
        min_score = 8'd0;
`endif

        // Empty pass can only be forced with the filter; otherwise a single-entry pass.
        send(8'd0, 24'd77, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/topk_score_buffer.md
TOPK_SCORE_BUFFER -- requirements
Module: topk_score_buffer

Interface
REQ-001 Parameter DEPTH, default 10: number of best candidates retained (2..32).
REQ-002 Parameter SCORE_W, default 8: candidate score width, unsigned.
REQ-003 Parameter TAG_W, default 24: candidate tag width (theta in [TAG_W-1:TAG_W/2], phi in [TAG_W/2-1:0]).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 clear  in  1  synchronous restart of a search pass.
REQ-007 in_valid  in  1  candidate offered.
REQ-008 in_ready  out  1  candidate can be accepted.
REQ-009 in_score  in  SCORE_W  candidate score.
REQ-010 in_tag  in  TAG_W  candidate angle tag.
REQ-011 in_last  in  1  qualifies the final candidate of a pass.
REQ-012 out_valid  out  1  ranked entry presented.
REQ-013 out_ready  in  1  consumer accepts ranked entry.
REQ-014 out_score  out  SCORE_W  ranked score, best first.
REQ-015 out_tag  out  TAG_W  ranked tag.
REQ-016 out_rank  out  $clog2(DEPTH)  rank of presented entry, 0 = best.
REQ-017 count  out  $clog2(DEPTH+1)  number of valid stored entries.
REQ-018 done  out  1  one-cycle pulse after the pass is fully drained.

Function
REQ-019 States IDLE, FILL, DRAIN; IDLE->FILL on accepted input without in_last; IDLE/FILL->DRAIN on accepted input with in_last; DRAIN->IDLE after the last drain handshake.
REQ-020 in_ready SHALL be 1 in IDLE and FILL, 0 in DRAIN; accept = in_valid & in_ready.
REQ-021 Storage SHALL be kept sorted descending by score every cycle; an accepted candidate is inserted in one cycle and visible in count/storage at the next edge.
REQ-022 Ties: new candidate SHALL be placed after all stored entries of equal score (earliest wins).
REQ-023 When count==DEPTH, a candidate with score <= the worst stored score SHALL be discarded; otherwise it is inserted and the worst entry evicted; count saturates at DEPTH.
REQ-024 In DRAIN, out_valid SHALL be 1 from the cycle after entering DRAIN while entries remain; rank advances 0..count-1 only on out_valid & out_ready; outputs stable while stalled.
REQ-025 done SHALL pulse one cycle after the final drain handshake; if in_last arrives with count==0 after insertion filtering, done pulses the cycle after entering DRAIN with out_valid never asserted.
REQ-026 On DRAIN->IDLE, count SHALL return to 0 and storage be invalidated.
REQ-027 clear SHALL, in any state, return to IDLE with count=0 next edge; a simultaneous in_valid is dropped; no done pulse.
REQ-028 Score comparisons SHALL be unsigned over full SCORE_W; no truncation.

Reset
REQ-029 On rst=1: state IDLE, count=0, in_ready=1, out_valid=0, done=0, out_score=0, out_tag=0, out_rank=0.
REQ-030 rst SHALL take priority over clear and all handshakes, including mid-DRAIN; partially drained results are lost.

Configuration
REQ-031 Macro TOPK_MIN_SCORE_EN: when defined, input port min_score [SCORE_W-1:0] exists and candidates with in_score < min_score are accepted (handshake completes, in_last honoured) but not stored.
REQ-032 Without TOPK_MIN_SCORE_EN: no min_score port; every accepted candidate is eligible for insertion.

Verification (DEPTH=10, SCORE_W=8, TAG_W=24)
REQ-033 Scores 5,9,1,9,7 (tags 1..5), last on 5th, out_ready=1 -> out 9/t2,9/t4,7/t5,5/t1,1/t3, ranks 0..4, done one cycle after rank 4.
REQ-034 Scores 1..15 ascending, last on 15th -> count=10, drain 15 down to 6.
REQ-035 Full buffer worst=20, input score 20 -> discarded, count stays 10, contents unchanged.
REQ-036 Drain with out_ready toggled 1,0,0,1 -> each entry held during stall, no skipped/duplicated rank.
REQ-037 clear asserted mid-FILL with count=6 and in_valid=1 -> next cycle IDLE, count=0, no done; rst mid-DRAIN -> REQ-029 values next cycle.
REQ-038 TOPK_MIN_SCORE_EN, min_score=50, scores 40,60,50, last on 3rd -> drain 60,50 only; 40 in_last-only pass -> done without out_valid.
